// File: rtl/mult_div_unit_pkg.sv
// Shared constants for the E-stage multiply/divide unit.
// Op codes and default latencies used by the unit and its bench.
package mult_div_unit_pkg;

    typedef logic [3:0] op_t;

    localparam op_t OP_MULT  = 4'd0;
    localparam op_t OP_MULTU = 4'd1;
    localparam op_t OP_DIV   = 4'd2;
    localparam op_t OP_DIVU  = 4'd3;
    localparam op_t OP_MTHI  = 4'd4;
    localparam op_t OP_MTLO  = 4'd5;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

endpackage

// File: rtl/mult_div_unit_if.sv
// E-stage request/response bundle of the multiply/divide unit.
// The pipeline drives the master side; the unit is the slave.
interface mult_div_unit_if;

    logic                    md_en;
    logic                    start;
    mult_div_unit_pkg::op_t  op;
    logic [31:0]             rs_data;
    logic [31:0]             rt_data;
    logic                    req;
    logic                    busy;
    logic [31:0]             hi;
    logic [31:0]             lo;

    modport master (
        output md_en, start, op, rs_data, rt_data, req,
        input  busy, hi, lo
    );

    modport slave (
        input  md_en, start, op, rs_data, rt_data, req,
        output busy, hi, lo
    );

endinterface

// File: rtl/mult_div_unit.sv
// E-stage multiply/divide unit owning the architectural HI/LO pair.
// Result is computed at issue, held pending, committed after the latency.
module mult_div_unit
    import mult_div_unit_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic           clk,
    input  logic           reset_n,
    mult_div_unit_if.slave md
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    logic [0:0]  state;
    logic [3:0]  count;
    logic [31:0] pend_hi;
    logic [31:0] pend_lo;
    logic        pend_wr;
    logic [31:0] hi_q;
    logic [31:0] lo_q;

    logic        is_mul;
    logic        is_div;
    logic        issue;
    logic        commit;
    logic        mthi_wr;
    logic        mtlo_wr;

    logic [63:0] smul;
    logic [63:0] umul;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] b_nz;
    logic [31:0] ub_nz;
    logic [31:0] sq_mag;
    logic [31:0] sr_mag;
    logic [31:0] uq;
    logic [31:0] ur;

    logic [31:0] res_hi;
    logic [31:0] res_lo;
    logic        res_wr;

    assign is_mul = (md.op == OP_MULT) || (md.op == OP_MULTU);
    assign is_div = (md.op == OP_DIV)  || (md.op == OP_DIVU);

    assign issue = md.md_en && md.start && !md.req
                && (state == S_IDLE) && (is_mul || is_div);

    assign commit = (state == S_RUN) && (count == 4'd1);

    assign mthi_wr = md.md_en && !md.start && !md.req
                  && (md.op == OP_MTHI);
    assign mtlo_wr = md.md_en && !md.start && !md.req
                  && (md.op == OP_MTLO);

    assign smul = $signed({{32{md.rs_data[31]}}, md.rs_data})
                * $signed({{32{md.rt_data[31]}}, md.rt_data});
    assign umul = {32'd0, md.rs_data} * {32'd0, md.rt_data};

    // Signed divide runs on magnitudes so INT_MIN/-1 needs no special case.
    assign a_mag  = md.rs_data[31] ? -md.rs_data : md.rs_data;
    assign b_mag  = md.rt_data[31] ? -md.rt_data : md.rt_data;
    assign b_nz   = (b_mag == 32'd0) ? 32'd1 : b_mag;
    assign sq_mag = a_mag / b_nz;
    assign sr_mag = a_mag % b_nz;

    assign ub_nz = (md.rt_data == 32'd0) ? 32'd1 : md.rt_data;
    assign uq    = md.rs_data / ub_nz;
    assign ur    = md.rs_data % ub_nz;

    // Select the 64-bit result; a zero divisor suppresses the commit.
    always_comb begin
        res_hi = 32'd0;
        res_lo = 32'd0;
        res_wr = 1'b1;
        unique case (1'b1)
            md.op == OP_MULT: begin
                res_hi = smul[63:32];
                res_lo = smul[31:0];
            end
            md.op == OP_MULTU: begin
                res_hi = umul[63:32];
                res_lo = umul[31:0];
            end
            md.op == OP_DIV: begin
                res_lo = (md.rs_data[31] ^ md.rt_data[31]) ? -sq_mag : sq_mag;
                res_hi = md.rs_data[31] ? -sr_mag : sr_mag;
                res_wr = (md.rt_data != 32'd0);
            end
            md.op == OP_DIVU: begin
                res_lo = uq;
                res_hi = ur;
                res_wr = (md.rt_data != 32'd0);
            end
            default: res_wr = 1'b0;
        endcase
    end

    // Latency FSM: capture the pending result and count down the window.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= S_IDLE;
            count   <= 4'd0;
            pend_hi <= 32'd0;
            pend_lo <= 32'd0;
            pend_wr <= 1'b0;
        end else if (issue) begin
            state   <= S_RUN;
            count   <= is_mul ? 4'(MULT_CYCLES) : 4'(DIV_CYCLES);
            pend_hi <= res_hi;
            pend_lo <= res_lo;
            pend_wr <= res_wr;
        end else if (state == S_RUN) begin
            if (count == 4'd1) begin
                state   <= S_IDLE;
                count   <= 4'd0;
                pend_wr <= 1'b0;
            end else begin
                count <= count - 4'd1;
            end
        end
    end

    // HI/LO update: a committing result beats a same-edge MTHI/MTLO.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hi_q <= 32'd0;
            lo_q <= 32'd0;
        end else begin
            if (commit && pend_wr) begin
                hi_q <= pend_hi;
            end else if (mthi_wr) begin
                hi_q <= md.rs_data;
            end
            if (commit && pend_wr) begin
                lo_q <= pend_lo;
            end else if (mtlo_wr) begin
                lo_q <= md.rs_data;
            end
        end
    end

    assign md.busy = (state == S_RUN);
    assign md.hi   = hi_q;
    assign md.lo   = lo_q;

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- E-stage multiply/divide unit holding the architectural HI/LO registers.
- Consumes the control unit's start, MULTDIVControl and multdiv-class flag (pipelined into E) plus forwarded rs/rt operands.
- Produces HI/LO for mfhi/mflo (CalcResultSrc HI/LO paths), and busy for the hazard unit.
- Models multi-cycle latency with a counter FSM; the arithmetic itself is computed at issue and committed at the end of the latency window.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (legal range 1..15).
- DIV_CYCLES, 10, busy cycles for div/divu (legal range 1..15).

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- md_en  in  1  instruction in E is multdiv-class (valid qualifier).
- start  in  1  instruction in E is mult/multu/div/divu.
- op  in  4  0=MULT, 1=MULTU, 2=DIV, 3=DIVU, 4=MTHI, 5=MTLO; others are no-ops.
- rs_data  in  32  forwarded rs operand.
- rt_data  in  32  forwarded rt operand.
- req  in  1  exception/interrupt flush this cycle; kills E-stage issue.
- busy  out  1  operation in flight.
- hi  out  32  HI register.
- lo  out  32  LO register.

Behaviour:
- Reset (async, reset_n=0): hi=0, lo=0, busy=0, counter=0, pending regs=0, state IDLE. Reset mid-operation abandons it; no commit follows.
- States:
  - IDLE: busy=0.
  - RUN: busy=1, counter counts down.
- Issue condition: md_en & start & !req & state==IDLE, sampled at the rising edge.
  - On issue: compute the 64-bit result from rs_data/rt_data into pending_hi/pending_lo.
  - Load counter with MULT_CYCLES (op 0/1) or DIV_CYCLES (op 2/3); go to RUN.
- Latency: if issue occurs at edge T, busy=1 for exactly N cycles after T. At the Nth edge after T, hi/lo take the pending values, busy returns to 0 and state returns to IDLE.
- MULT: {hi,lo} = signed(rs) * signed(rt), 64-bit. MULTU: unsigned product.
- DIV: lo = quotient truncated toward zero; hi = remainder with the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- DIVU: unsigned quotient and remainder.
- Divide by zero (rt=0, DIV or DIVU): full DIV_CYCLES busy window still runs; hi/lo are left unchanged at commit.
- MTHI/MTLO: md_en & !start & !req & op==4/5 writes rs_data into hi/lo at the next edge. Effective in any state.
  - If this write coincides with a commit edge, the commit wins for that register.
- start while RUN: ignored. The hazard unit stalls D while busy|start, so this cannot occur in legal operation.
- req=1: blocks issue and MTHI/MTLO in that cycle. An already-running operation continues and commits, because it is older than the faulting instruction.
- op values 6..15 with md_en: no state change.
- hi/lo are registered outputs and stay stable during RUN. mfhi/mflo cannot read mid-operation because the hazard unit stalls them.

Decomposition:
- Shared constants file (alongside the existing opcode/func macros): op codes 0..5, default MULT_CYCLES/DIV_CYCLES.
- Single module; no sub-module. The arithmetic is a combinational block inside it; the counter/FSM is the only sequential logic besides the HI/LO and pending registers.

Test Plan:
1. Reset low mid-RUN (two cycles after a mult issue), then release → hi=0, lo=0, busy=0 immediately; no later commit.
2. MULT rs=0xFFFFFFFE (-2), rt=3 → busy high exactly 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA. MULTU with the same operands → hi=0x00000002, lo=0xFFFFFFFA.
3. DIV rs=-7 (0xFFFFFFF9), rt=2 → busy 10 cycles; then lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 7/2 → lo=3, hi=1.
4. Preload hi=0x11, lo=0x22 via MTHI/MTLO, then DIV by 0 → busy 10 cycles; hi=0x11, lo=0x22 unchanged.
5. start=1 with req=1 (MULT 2*3) → busy stays 0, hi/lo unchanged. MTLO with req=1 → lo unchanged.
6. Issue MULT 4*5, then MTLO 0x99 on the commit edge → lo=20 (commit wins). MTHI 0xAB two cycles into a DIV 9/4 → hi=0xAB during RUN, then hi=1, lo=2 at commit.
